// File: rtl/uart_mmio_ctrl_pkg.sv
// Shared definitions for the MIPS150 UART / performance-counter MMIO block:
// the word addresses of every register, status bit positions and the
// address decoder used by the controller.
package uart_mmio_ctrl_pkg;

   localparam logic [31:0] ADDR_TX_STATUS = 32'h8000_0000;
   localparam logic [31:0] ADDR_RX_STATUS = 32'h8000_0004;
   localparam logic [31:0] ADDR_TX_DATA   = 32'h8000_0008;
   localparam logic [31:0] ADDR_RX_DATA   = 32'h8000_000C;
   localparam logic [31:0] ADDR_CYCLE_CNT = 32'h8000_0010;
   localparam logic [31:0] ADDR_INSTR_CNT = 32'h8000_0014;
   localparam logic [31:0] ADDR_CNT_CLEAR = 32'h8000_0018;

   // Bit inside the status words that carries the flag.
   localparam int TX_EMPTY_BIT = 0;
   localparam int RX_VALID_BIT = 0;

   // One-hot view of which register an address selects. At most one
   // field is set; an unmapped address sets none.
   typedef struct packed {
      logic tx_status;
      logic rx_status;
      logic tx_data;
      logic rx_data;
      logic cycle_cnt;
      logic instr_cnt;
      logic cnt_clear;
   } io_sel_t;

   // Exact word-address match only; partial or misaligned addresses miss.
   function automatic io_sel_t decode_addr(input logic [31:0] addr);
      io_sel_t sel;
      sel.tx_status = (addr == ADDR_TX_STATUS);
      sel.rx_status = (addr == ADDR_RX_STATUS);
      sel.tx_data   = (addr == ADDR_TX_DATA);
      sel.rx_data   = (addr == ADDR_RX_DATA);
      sel.cycle_cnt = (addr == ADDR_CYCLE_CNT);
      sel.instr_cnt = (addr == ADDR_INSTR_CNT);
      sel.cnt_clear = (addr == ADDR_CNT_CLEAR);
      return sel;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO buffering characters from the UART receiver.
// Push is refused when full, pop is refused when empty; a simultaneous
// push and pop moves both pointers and leaves the occupancy unchanged.
module uart_rx_fifo #(
   parameter int RX_DEPTH = 8,
   parameter int RX_AW    = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic [7:0]   wdata_i,
   input  logic         pop_i,
   output logic [7:0]   head_o,
   output logic         full_o,
   output logic         empty_o,
   output logic [RX_AW:0] count_o
);

   localparam logic [RX_AW:0]   DEPTH_C = (RX_AW + 1)'(RX_DEPTH);
   localparam logic [RX_AW:0]   CNT_ONE = (RX_AW + 1)'(1);
   localparam logic [RX_AW-1:0] PTR_ONE = RX_AW'(1);

   logic [7:0]       mem [RX_DEPTH];
   logic [RX_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [RX_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [RX_AW:0]   count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == DEPTH_C);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Next pointers and occupancy; pointers wrap naturally at RX_DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy state; reset discards any buffered bytes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// MMIO controller at 0x8000_00xx for the MIPS150 datapath: UART TX holding
// register, RX FIFO, cycle and retired-instruction counters. Load data is
// registered so it lines up with the one-cycle data-memory read path.
module uart_mmio_ctrl
   import uart_mmio_ctrl_pkg::*;
#(
   parameter int RX_DEPTH = 8,
   parameter int RX_AW    = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        we,
   input  logic        re,
   input  logic        instr_retire,
   output logic [31:0] ReadData,
   output logic [7:0]  DataIn,
   output logic        DataInValid,
   input  logic        DataInReady,
   input  logic [7:0]  DataOut,
   input  logic        DataOutValid,
   output logic        DataOutReady
);

   io_sel_t        sel;
   logic [31:0]    read_q, read_d;
   logic           tx_full_q, tx_full_d;
   logic [7:0]     tx_byte_q, tx_byte_d;
   logic [31:0]    cycle_q, cycle_d;
   logic [31:0]    instr_q, instr_d;
   logic           rx_pop;
   logic [7:0]     rx_head;
   logic           rx_full;
   logic           rx_empty;
   logic [RX_AW:0] rx_count;
   logic           tx_write;
   logic           tx_xfer;
   logic           cnt_clear;

   assign sel       = decode_addr(Address);
   assign tx_write  = we && sel.tx_data;
   assign tx_xfer   = tx_full_q && DataInReady;
   assign cnt_clear = we && sel.cnt_clear;
   assign rx_pop    = re && sel.rx_data;

   assign ReadData     = read_q;
   assign DataIn       = tx_byte_q;
   assign DataInValid  = tx_full_q;
   assign DataOutReady = !rx_full;

   uart_rx_fifo #(
      .RX_DEPTH (RX_DEPTH),
      .RX_AW    (RX_AW)
   ) u_rx_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (DataOutValid),
      .wdata_i (DataOut),
      .pop_i   (rx_pop),
      .head_o  (rx_head),
      .full_o  (rx_full),
      .empty_o (rx_empty),
      .count_o (rx_count)
   );

   // Load result: sampled from current state when re is high, held otherwise.
   always_comb begin
      read_d = read_q;
      if (re) begin
         read_d = '0;
         if (sel.tx_status) begin
            read_d[TX_EMPTY_BIT] = !tx_full_q;
         end
         if (sel.rx_status) begin
            read_d[RX_VALID_BIT] = !rx_empty;
         end
         if (sel.rx_data && !rx_empty) begin
            read_d = {24'b0, rx_head};
         end
         if (sel.cycle_cnt) begin
            read_d = cycle_q;
         end
         if (sel.instr_cnt) begin
            read_d = instr_q;
         end
      end
   end

   // TX holding register: a store is accepted when empty or when the held
   // byte leaves in the same cycle; otherwise the store is dropped.
   always_comb begin
      tx_full_d = tx_full_q;
      tx_byte_d = tx_byte_q;
      if (tx_write && (!tx_full_q || tx_xfer)) begin
         tx_full_d = 1'b1;
         tx_byte_d = WriteData[7:0];
      end else if (tx_xfer) begin
         tx_full_d = 1'b0;
      end
   end

   // Performance counters: clear takes priority over counting.
   always_comb begin
      cycle_d = cycle_q + 32'd1;
      instr_d = instr_q + 32'(instr_retire);
      if (cnt_clear) begin
         cycle_d = '0;
         instr_d = '0;
      end
   end

   // State registers for read data, TX holding and counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         read_q    <= '0;
         tx_full_q <= 1'b0;
         tx_byte_q <= '0;
         cycle_q   <= '0;
         instr_q   <= '0;
      end else begin
         read_q    <= read_d;
         tx_full_q <= tx_full_d;
         tx_byte_q <= tx_byte_d;
         cycle_q   <= cycle_d;
         instr_q   <= instr_d;
      end
   end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl: directed scenarios plus random
// traffic compared against a queue-based behavioural model.
module tb_uart_mmio_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        we;
   logic        re;
   logic        instr_retire;
   logic [31:0] ReadData;
   logic [7:0]  DataIn;
   logic        DataInValid;
   logic        DataInReady;
   logic [7:0]  DataOut;
   logic        DataOutValid;
   logic        DataOutReady;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [7:0]  rx_m[$];
   logic        tx_full_m;
   logic [7:0]  tx_byte_m;
   logic [31:0] cyc_m;
   logic [31:0] ins_m;
   logic [31:0] rd_m;

   localparam logic [31:0] A_TXS = 32'h8000_0000;
   localparam logic [31:0] A_RXS = 32'h8000_0004;
   localparam logic [31:0] A_TXD = 32'h8000_0008;
   localparam logic [31:0] A_RXD = 32'h8000_000C;
   localparam logic [31:0] A_CYC = 32'h8000_0010;
   localparam logic [31:0] A_INS = 32'h8000_0014;
   localparam logic [31:0] A_CLR = 32'h8000_0018;

   uart_mmio_ctrl #(.RX_DEPTH(8), .RX_AW(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .Address      (Address),
      .WriteData    (WriteData),
      .we           (we),
      .re           (re),
      .instr_retire (instr_retire),
      .ReadData     (ReadData),
      .DataIn       (DataIn),
      .DataInValid  (DataInValid),
      .DataInReady  (DataInReady),
      .DataOut      (DataOut),
      .DataOutValid (DataOutValid),
      .DataOutReady (DataOutReady)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      rx_m.delete();
      tx_full_m = 1'b0;
      tx_byte_m = 8'h00;
      cyc_m     = 32'd0;
      ins_m     = 32'd0;
      rd_m      = 32'd0;
   endtask

   task automatic idle_inputs();
      Address = 32'h0; WriteData = 32'h0; we = 1'b0; re = 1'b0;
      instr_retire = 1'b0; DataInReady = 1'b0; DataOut = 8'h00; DataOutValid = 1'b0;
   endtask

   // Drive one cycle of inputs, advance the model, then sample 1 time unit
   // after the edge.
   task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic w,
                       input logic r, input logic ret, input logic dv,
                       input logic [7:0] db, input logic dr);
      logic push, pop;
      Address = a; WriteData = wd; we = w; re = r; instr_retire = ret;
      DataOutValid = dv; DataOut = db; DataInReady = dr;
      if (r) begin
         case (a)
            A_TXS:   rd_m = tx_full_m ? 32'd0 : 32'd1;
            A_RXS:   rd_m = (rx_m.size() != 0) ? 32'd1 : 32'd0;
            A_RXD:   rd_m = (rx_m.size() != 0) ? {24'd0, rx_m[0]} : 32'd0;
            A_CYC:   rd_m = cyc_m;
            A_INS:   rd_m = ins_m;
            default: rd_m = 32'd0;
         endcase
      end
      pop  = r && (a == A_RXD) && (rx_m.size() != 0);
      push = dv && (rx_m.size() < 8);
      if (w && a == A_TXD && (!tx_full_m || dr)) begin
         tx_full_m = 1'b1;
         tx_byte_m = wd[7:0];
      end else if (tx_full_m && dr) begin
         tx_full_m = 1'b0;
      end
      if (w && a == A_CLR) begin
         cyc_m = 32'd0;
         ins_m = 32'd0;
      end else begin
         cyc_m = cyc_m + 32'd1;
         ins_m = ins_m + (ret ? 32'd1 : 32'd0);
      end
      if (pop) void'(rx_m.pop_front());
      if (push) rx_m.push_back(db);
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (DataOutReady !== 1'b1 || DataInValid !== 1'b0 || DataIn !== 8'h00 || ReadData !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b val=%b din=%h rd=%h, expected 1 0 00 00000000",
                  DataOutReady, DataInValid, DataIn, ReadData);
      end
      step(A_TXS, 0, 0, 1, 0, 0, 0, 0);
      checks++;
      if (ReadData !== 32'h1) begin
         errors++; $display("FAIL reset_tx_status: got %h expected 00000001", ReadData);
      end
      step(A_RXS, 0, 0, 1, 0, 0, 0, 0);
      checks++;
      if (ReadData !== 32'h0) begin
         errors++; $display("FAIL reset_rx_status: got %h expected 00000000", ReadData);
      end
      // re low keeps the last load result
      step(A_TXS, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (ReadData !== 32'h0) begin
         errors++; $display("FAIL read_hold: got %h expected 00000000", ReadData);
      end
   endtask

   task automatic test_tx();
      step(A_TXD, 32'h0000_0041, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (DataInValid !== 1'b1 || DataIn !== 8'h41) begin
            errors++; $display("FAIL tx_hold[%0d]: got val=%b din=%h expected 1 41", i, DataInValid, DataIn);
         end
         step(32'h0, 0, 0, 0, 0, 0, 0, 0);
      end
      step(A_TXD, 32'h0000_0042, 1, 0, 0, 0, 0, 0);
      checks++;
      if (DataIn !== 8'h41 || DataIn !== tx_byte_m) begin
         errors++; $display("FAIL tx_drop: got din=%h expected 41", DataIn);
      end
      step(32'h0, 0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (DataInValid !== 1'b0) begin
         errors++; $display("FAIL tx_xfer: got val=%b expected 0", DataInValid);
      end
      step(A_TXS, 0, 0, 1, 0, 0, 0, 0);
      checks++;
      if (ReadData !== 32'h1) begin
         errors++; $display("FAIL tx_status_empty: got %h expected 00000001", ReadData);
      end
      // store in the same cycle the held byte leaves: new byte replaces it
      step(A_TXD, 32'h0000_0055, 1, 0, 0, 0, 0, 0);
      step(A_TXD, 32'h0000_0066, 1, 0, 0, 0, 0, 1);
      checks++;
      if (DataInValid !== 1'b1 || DataIn !== 8'h66) begin
         errors++; $display("FAIL tx_xfer_and_load: got val=%b din=%h expected 1 66", DataInValid, DataIn);
      end
      step(32'h0, 0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (DataInValid !== tx_full_m) begin
         errors++; $display("FAIL tx_final: got val=%b expected %b", DataInValid, tx_full_m);
      end
   endtask

   task automatic test_rx_fill();
      for (int i = 0; i < 9; i++) begin
         step(32'h0, 0, 0, 0, 0, 1, 8'(8'h10 + i), 0);
         checks++;
         if (DataOutReady !== (i < 7 ? 1'b1 : 1'b0)) begin
            errors++; $display("FAIL rx_ready[%0d]: got %b expected %b", i, DataOutReady, (i < 7));
         end
      end
      for (int i = 0; i < 9; i++) begin
         step(A_RXD, 0, 0, 1, 0, 0, 0, 0);
         checks++;
         if (ReadData !== (i < 8 ? 32'(8'h10 + i) : 32'h0) || ReadData !== rd_m) begin
            errors++; $display("FAIL rx_pop[%0d]: got %h expected %h", i, ReadData, rd_m);
         end
      end
   endtask

   task automatic test_rx_wrap();
      for (int i = 0; i < 8; i++) step(32'h0, 0, 0, 0, 0, 1, 8'($urandom), 0);
      // pop while full with receiver offering a byte: the byte is refused
      step(A_RXD, 0, 0, 1, 0, 1, 8'hEE, 0);
      checks++;
      if (ReadData !== rd_m || DataOutReady !== 1'b1) begin
         errors++; $display("FAIL rx_full_pop: got rd=%h rdy=%b expected %h 1", ReadData, DataOutReady, rd_m);
      end
      for (int i = 0; i < 4; i++) step(A_RXD, 0, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         step(A_RXD, 0, 0, 1, 0, 1, 8'($urandom), 0);
         checks++;
         if (ReadData !== rd_m || rx_m.size() != 3) begin
            errors++; $display("FAIL rx_push_pop[%0d]: got %h expected %h", i, ReadData, rd_m);
         end
      end
      for (int i = 0; i < 4; i++) begin
         step(A_RXD, 0, 0, 1, 0, 0, 0, 0);
         checks++;
         if (ReadData !== rd_m) begin
            errors++; $display("FAIL rx_drain[%0d]: got %h expected %h", i, ReadData, rd_m);
         end
      end
      // push and pop while empty: read yields 0, the byte is kept
      step(A_RXD, 0, 0, 1, 0, 1, 8'hA5, 0);
      checks++;
      if (ReadData !== 32'h0) begin
         errors++; $display("FAIL rx_empty_push_pop: got %h expected 00000000", ReadData);
      end
      step(A_RXD, 0, 0, 1, 0, 0, 0, 0);
      checks++;
      if (ReadData !== 32'h0000_00A5) begin
         errors++; $display("FAIL rx_after_empty_push: got %h expected 000000a5", ReadData);
      end
   endtask

   task automatic test_counters();
      bit ret_tab[100];
      int n = 0;
      while (n < 40) begin
         int k = $urandom_range(0, 99);
         if (!ret_tab[k]) begin
            ret_tab[k] = 1'b1;
            n++;
         end
      end
      step(A_CLR, 32'h1234, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 100; i++) step(32'h0, 0, 0, 0, ret_tab[i], 0, 0, 0);
      step(A_CYC, 0, 0, 1, 1, 0, 0, 0);
      checks++;
      if (ReadData !== 32'd100 || ReadData !== rd_m) begin
         errors++; $display("FAIL cycle_count: got %0d expected 100", ReadData);
      end
      step(A_INS, 0, 0, 1, 0, 0, 0, 0);
      checks++;
      if (ReadData !== 32'd41) begin
         errors++; $display("FAIL instr_count: got %0d expected 41", ReadData);
      end
      step(A_CLR, 32'h0, 1, 0, 1, 0, 0, 0);
      step(A_CYC, 0, 0, 1, 0, 0, 0, 0);
      checks++;
      if (ReadData !== 32'd0) begin
         errors++; $display("FAIL cycle_clear: got %0d expected 0", ReadData);
      end
      step(A_INS, 0, 0, 1, 0, 0, 0, 0);
      checks++;
      if (ReadData !== 32'd0) begin
         errors++; $display("FAIL instr_clear: got %0d expected 0", ReadData);
      end
   endtask

   task automatic test_random();
      logic [31:0] addrs [10];
      addrs = '{A_TXS, A_RXS, A_TXD, A_RXD, A_CYC, A_INS, A_CLR,
                32'h8000_001C, 32'h8000_0001, 32'h0000_0004};
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         a = addrs[$urandom_range(0, 9)];
         step(a, $urandom, ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom), ($urandom_range(0, 2) == 0));
         checks++;
         if (ReadData !== rd_m || DataInValid !== tx_full_m || DataIn !== tx_byte_m ||
             DataOutReady !== (rx_m.size() < 8)) begin
            errors++;
            $display("FAIL random[%0d] addr=%h: got rd=%h val=%b din=%h rdy=%b expected %h %b %h %b",
                     i, a, ReadData, DataInValid, DataIn, DataOutReady,
                     rd_m, tx_full_m, tx_byte_m, (rx_m.size() < 8));
         end
      end
   endtask

   task automatic test_reset_mid();
      step(A_TXD, 32'h77, 1, 0, 0, 0, 0, 0);
      while (rx_m.size() < 5) step(32'h0, 0, 0, 0, 0, 1, 8'($urandom), 0);
      while (rx_m.size() > 5) step(A_RXD, 0, 0, 1, 0, 0, 0, 0);
      step(A_CYC, 0, 0, 1, 0, 0, 0, 0);
      reset = 1'b1;
      #1;
      checks++;
      if (DataInValid !== 1'b0 || DataOutReady !== 1'b1 || ReadData !== 32'h0) begin
         errors++; $display("FAIL async_reset: got val=%b rdy=%b rd=%h expected 0 1 00000000",
                            DataInValid, DataOutReady, ReadData);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      step(A_TXS, 0, 0, 1, 0, 0, 0, 0);
      checks++;
      if (ReadData !== 32'h1) begin
         errors++; $display("FAIL post_reset_tx: got %h expected 00000001", ReadData);
      end
      step(A_RXS, 0, 0, 1, 0, 0, 0, 0);
      checks++;
      if (ReadData !== 32'h0) begin
         errors++; $display("FAIL post_reset_rx: got %h expected 00000000", ReadData);
      end
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      model_reset();
      test_reset();
      test_tx();
      test_rx_fill();
      test_rx_wrap();
      test_counters();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
Memory-mapped I/O controller that lets the MIPS150 datapath reach the UART and the performance counters at 0x8000_00xx. It decodes load/store accesses from the MEM stage, buffers received bytes in a small FIFO and holds one byte for transmit. It runs the valid/ready handshakes with the UART transmitter and receiver, and returns registered read data to the writeback mux with the same 1-cycle latency as data memory.

Parameters:
RX_DEPTH, 8, RX FIFO entries (power of 2, >=2)
RX_AW, 3, log2(RX_DEPTH)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
Address  in  32  MEM-stage byte address
WriteData  in  32  store data; byte 0 used for TX
we  in  1  store qualified (not killed) this cycle
re  in  1  load qualified this cycle
instr_retire  in  1  one instruction retired this cycle
ReadData  out  32  registered load result, valid the cycle after re
DataIn  out  8  byte to UART transmitter
DataInValid  out  1  TX holding register full
DataInReady  in  1  transmitter accepts byte
DataOut  in  8  byte from UART receiver
DataOutValid  in  1  receiver has byte
DataOutReady  out  1  RX FIFO not full

Behaviour:
- Address map (only exact word addresses match; else no effect, ReadData=0):
  0x80000000 R: bit0 = TX holding empty
  0x80000004 R: bit0 = RX FIFO non-empty
  0x80000008 W: load TX holding register with WriteData[7:0]
  0x8000000C R: pop RX FIFO, {24'b0, head byte}
  0x80000010 R: cycle counter
  0x80000014 R: retired-instruction counter
  0x80000018 W: any value clears both counters
- Reset (async): TX holding empty, DataInValid=0, DataIn=0, FIFO empty (DataOutReady=1 after reset releases), counters=0, ReadData=0. Reset mid-transfer discards held/buffered bytes.
- Read latency: ReadData registered; reflects state sampled on the re edge; holds value until next re. re=0 leaves ReadData unchanged.
- TX: write to 0x80000008 while empty -> full next cycle, DataInValid=1, DataIn=byte. Transfer when DataInValid&&DataInReady -> empty next cycle. Write while full -> dropped, holding unchanged. Transfer and write in same cycle -> new byte loaded, stays full.
- RX: DataOutReady = !full (combinational from count). Push on DataOutValid&&DataOutReady. Pop on re to 0x8000000C when non-empty; empty pop returns 0, no pointer change. Simultaneous push+pop: count unchanged, both pointers advance; push when empty with pop -> read returns 0, entry stored. Pointers wrap modulo RX_DEPTH; count width RX_AW+1.
- Counters: 32-bit, wrap 0xFFFFFFFF->0. Cycle counter +1 every cycle; instr counter +1 when instr_retire. Clear write wins over increment in same cycle (both 0 next cycle). Read and increment in same cycle returns pre-increment value.
- we and re both high: treated independently (decode by address; only one address can match).

Decomposition:
- Shared include IOmap.vh: the seven address constants and status bit positions; used also by the control decode.
- One sub-module: uart_rx_fifo (sync FIFO, push/pop/full/empty/head, parameterised by RX_DEPTH). TX holding register, decode and counters remain in this module.

Test Plan:
- Reset then read 0x80000000 and 0x80000004 -> ReadData 0x1 then 0x0; DataOutReady=1, DataInValid=0.
- Store 0x41 to 0x80000008 with DataInReady=0 for 3 cycles -> DataInValid=1, DataIn=0x41 held; second store 0x42 dropped; DataInReady=1 -> DataInValid=0 next cycle, status reads 0x1.
- Push 8 bytes 0x10..0x17 -> DataOutReady=0 after 8th; 9th DataOutValid ignored; 8 reads of 0x8000000C return 0x10..0x17 in order; 9th read returns 0.
- FIFO at count 8, push blocked while a pop occurs; then at count 3, push+pop same cycle -> count stays 3, wrap across index 7->0 preserves order.
- Run 100 cycles with instr_retire high on 40 -> 0x80000010 reads 100 (±fixed offset from reset release), 0x80000014 reads 40; store to 0x80000018 -> both read 0 on next access cycle.
- Assert reset while TX full and FIFO holds 5 bytes -> immediately DataInValid=0, DataOutReady=1, status reads 0x1/0x0 after release.
